// File: rtl/wts_i2s_transmitter_if.sv
// ============================================================================
// Module      : wts_i2s_transmitter_if
// Description : Bus bundle between the mixer/DAC side and the I2S transmitter.
//               Optional macro WTS_I2S_MUTE_EN adds the 'mute' signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wts_i2s_transmitter_if;
    logic        enable;
    logic [11:0] left_in;
    logic [11:0] right_in;
`ifdef WTS_I2S_MUTE_EN
    logic        mute;
`endif
    logic        sample_strobe;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;

    // Driver side: supplies samples and control, observes the serial stream
    modport master (
`ifdef WTS_I2S_MUTE_EN
        output mute,
`endif
        output enable,
        output left_in,
        output right_in,
        input  sample_strobe,
        input  i2s_bclk,
        input  i2s_lrck,
        input  i2s_sdata
    );

    // Transmitter side
    modport slave (
`ifdef WTS_I2S_MUTE_EN
        input  mute,
`endif
        input  enable,
        input  left_in,
        input  right_in,
        output sample_strobe,
        output i2s_bclk,
        output i2s_lrck,
        output i2s_sdata
    );
endinterface

`default_nettype wire

// File: rtl/wts_i2s_transmitter.sv
// ============================================================================
// Module      : wts_i2s_transmitter
// Description : Serialises the mixer's 12-bit offset-binary left/right samples
//               as a 64-BCLK-per-frame I2S stream (16-bit two's complement,
//               MSB first, one-bit delay after LRCK). All outputs registered.
//               Optional macro WTS_I2S_MUTE_EN: adds 'mute', sampled only at
//               latch points, which loads silence into both holding words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wts_i2s_transmitter #(
    parameter int BCLK_DIV = 4   // clk cycles per BCLK half-period, >= 2
) (
    input  wire logic               clk,
    input  wire logic               nreset,
    wts_i2s_transmitter_if.slave    bus
);

    localparam int DIV_W = $clog2(BCLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [5:0]         r_bit_cnt;
    logic [15:0]        r_left;
    logic [15:0]        r_right;
    logic               r_bclk;
    logic               r_lrck;
    logic               r_sdata;
    logic               r_strobe;

    logic               w_mute;
    logic               w_div_tc;
    logic [5:0]         w_bit_next;
    logic [15:0]        w_left_word;
    logic [15:0]        w_right_word;
    logic               w_slot_bit;

`ifdef WTS_I2S_MUTE_EN
    assign w_mute = bus.mute;
`else
    assign w_mute = 1'b0;
`endif

    assign w_div_tc   = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_bit_next = r_bit_cnt + 6'd1;

    // Offset binary to two's complement: flip the sign bit, left-justify
    assign w_left_word  = w_mute ? 16'h0000 : {~bus.left_in[11],  bus.left_in[10:0],  4'b0000};
    assign w_right_word = w_mute ? 16'h0000 : {~bus.right_in[11], bus.right_in[10:0], 4'b0000};

    // Data for the slot being entered: the current count equals the new slot
    // minus one, so counts 0..15 carry left bits 15..0 and 32..47 carry right
    always_comb begin
        w_slot_bit = 1'b0;
        case (r_bit_cnt[5:4])
            2'b00:   w_slot_bit = r_left[~r_bit_cnt[3:0]];
            2'b10:   w_slot_bit = r_right[~r_bit_cnt[3:0]];
            default: w_slot_bit = 1'b0;
        endcase
    end

    // Framing FSM with divider, bit counter, holding registers and outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_strobe  <= 1'b0;
        end else if (!bus.enable) begin
            // Abort immediately; no attempt to finish the frame
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Entering LOAD: capture fresh samples, strobe is high during LOAD
                    r_state   <= S_LOAD;
                    r_left    <= w_left_word;
                    r_right   <= w_right_word;
                    r_strobe  <= 1'b1;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    r_bclk    <= 1'b0;
                    r_lrck    <= 1'b0;
                    r_sdata   <= 1'b0;
                end
                S_LOAD, S_RUN: begin
                    r_state  <= S_RUN;
                    r_strobe <= 1'b0;
                    if (w_div_tc) begin
                        r_div_cnt <= '0;
                        r_bclk    <= ~r_bclk;
                        // BCLK falling edge: advance slot, LRCK and SDATA together
                        if (r_bclk) begin
                            r_bit_cnt <= w_bit_next;
                            r_lrck    <= w_bit_next[5];
                            r_sdata   <= w_slot_bit;
                            if (r_bit_cnt == 6'd63) begin
                                r_left   <= w_left_word;
                                r_right  <= w_right_word;
                                r_strobe <= 1'b1;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sample_strobe = r_strobe;
    assign bus.i2s_bclk      = r_bclk;
    assign bus.i2s_lrck      = r_lrck;
    assign bus.i2s_sdata     = r_sdata;

endmodule

`default_nettype wire

// File: tb/tb_wts_i2s_transmitter.sv
// ============================================================================
// Module      : tb_wts_i2s_transmitter
// Description : Self-checking bench for wts_i2s_transmitter. The reference
//               model tracks clocks elapsed since the last sample latch and
//               derives BCLK/LRCK/SDATA/strobe from that with plain arithmetic.
//               Build with +define+WTS_I2S_MUTE_EN to exercise the mute option.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wts_i2s_transmitter;

    localparam int DIV   = 4;
    localparam int FRAME = 128 * DIV;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    logic tb_mute = 1'b0;

    always #5 clk = ~clk;

    wts_i2s_transmitter_if bus();

`ifdef WTS_I2S_MUTE_EN
    assign bus.mute = tb_mute;
`endif

    wts_i2s_transmitter #(.BCLK_DIV(DIV)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    logic [3:0] obs;
    assign obs = {bus.sample_strobe, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_run = 1'b0;
    int          m_k   = 0;
    logic [15:0] m_l   = '0;
    logic [15:0] m_r   = '0;

    // Sample value as signed arithmetic: (x - 2048) scaled to 16 bits
    function automatic logic [15:0] to_word(input logic [11:0] x);
        int v;
        v = (int'(x) - 2048) * 16;
        return v[15:0];
    endfunction

    task automatic model_latch();
        if (tb_mute) begin
            m_l = 16'h0000;
            m_r = 16'h0000;
        end else begin
            m_l = to_word(bus.left_in);
            m_r = to_word(bus.right_in);
        end
    endtask

    // Expected {strobe, bclk, lrck, sdata} from clocks elapsed since latch
    function automatic logic [3:0] model_out();
        int   b;
        logic sck, ws, sd, st;
        if (!m_run) return 4'b0000;
        b   = m_k / (2 * DIV);
        sck = ((m_k / DIV) % 2) == 1;
        ws  = (b >= 32);
        st  = (m_k == 0);
        sd  = 1'b0;
        if (b >= 1 && b <= 16)  sd = m_l[16 - b];
        if (b >= 33 && b <= 48) sd = m_r[48 - b];
        return {st, sck, ws, sd};
    endfunction

    // Apply the rules of one clock edge to the model, then move to the negedge
    task automatic cycle();
        if (!nreset || !bus.enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_k   = 0;
            model_latch();
        end else begin
            m_k = m_k + 1;
            if (m_k == FRAME) begin
                m_k = 0;
                model_latch();
            end
        end
        @(negedge clk);
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        nreset = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.left_in  = 12'($urandom);
            bus.right_in = 12'($urandom);
            cycle();
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, obs);
            end
        end
        nreset = 1'b1;
        cycle();
        checks++;
        if (bus.sample_strobe !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_strobe got=%b exp=1", bus.sample_strobe);
        end
        for (int i = 0; i < 300; i++) begin
            bus.left_in  = 12'($urandom);
            bus.right_in = 12'($urandom);
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL reset_run cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
        end
        // Asynchronous assertion in the middle of a clock period
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got=%b exp=0000", obs);
        end
        cycle();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_held got=%b exp=0000", obs);
        end
        nreset = 1'b1;
        bus.enable = 1'b0;
        cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_fullscale();
        logic [63:0] fb;
        logic [15:0] gl, gr;
        logic        rest;
        fb = '0;
        bus.left_in  = 12'hFFF;
        bus.right_in = 12'h000;
        restart();
        for (int i = 0; i < FRAME + 16; i++) begin
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL fullscale cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
            if (i < FRAME && (i % (2 * DIV)) == DIV) fb[i / (2 * DIV)] = bus.i2s_sdata;
        end
        gl = '0; gr = '0; rest = 1'b0;
        for (int b = 0; b < 64; b++) begin
            if (b >= 1 && b <= 16)       gl[16 - b] = fb[b];
            else if (b >= 33 && b <= 48) gr[48 - b] = fb[b];
            else                         rest = rest | fb[b];
        end
        checks++;
        if (gl !== 16'h7FF0) begin
            errors++;
            $display("FAIL fullscale_left got=%h exp=7ff0", gl);
        end
        checks++;
        if (gr !== 16'h8000) begin
            errors++;
            $display("FAIL fullscale_right got=%h exp=8000", gr);
        end
        checks++;
        if (rest !== 1'b0) begin
            errors++;
            $display("FAIL fullscale_idle_slots got=%b exp=0", rest);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timing();
        int   n_strobe, second_at, lr_hi, rises, bad_edges;
        logic p_bclk, p_lrck;
        n_strobe = 0; second_at = -1; lr_hi = 0; rises = 0; bad_edges = 0;
        p_bclk = 1'b0; p_lrck = 1'b0;
        bus.left_in  = 12'($urandom);
        bus.right_in = 12'($urandom);
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL timing cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
            if (bus.sample_strobe) begin
                n_strobe++;
                if (n_strobe == 2) second_at = i;
            end
            if (i < FRAME && bus.i2s_lrck) lr_hi++;
            if (i < FRAME && bus.i2s_bclk && !p_bclk) rises++;
            if (bus.i2s_lrck !== p_lrck && !(p_bclk && !bus.i2s_bclk)) bad_edges++;
            p_bclk = bus.i2s_bclk;
            p_lrck = bus.i2s_lrck;
        end
        checks++;
        if (n_strobe != 2 || second_at != FRAME) begin
            errors++;
            $display("FAIL timing_strobe_period got=%0d strobes second_at=%0d exp=2 at %0d",
                     n_strobe, second_at, FRAME);
        end
        checks++;
        if (lr_hi != FRAME / 2) begin
            errors++;
            $display("FAIL timing_lrck_high got=%0d exp=%0d", lr_hi, FRAME / 2);
        end
        checks++;
        if (rises != 64) begin
            errors++;
            $display("FAIL timing_bclk_rises got=%0d exp=64", rises);
        end
        checks++;
        if (bad_edges != 0) begin
            errors++;
            $display("FAIL timing_lrck_on_bclk_fall got=%0d stray edges exp=0", bad_edges);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold();
        logic        any1;
        logic [15:0] gl;
        any1 = 1'b0; gl = '0;
        bus.left_in  = 12'h800;
        bus.right_in = 12'h800;
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 10 * 2 * DIV) bus.left_in = 12'h801;
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
            if (i < FRAME) any1 = any1 | bus.i2s_sdata;
            else if ((i % (2 * DIV)) == DIV && (i - FRAME) / (2 * DIV) >= 1
                     && (i - FRAME) / (2 * DIV) <= 16)
                gl[16 - (i - FRAME) / (2 * DIV)] = bus.i2s_sdata;
        end
        checks++;
        if (any1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_silent_frame got=%b exp=0", any1);
        end
        checks++;
        if (gl !== 16'h0010) begin
            errors++;
            $display("FAIL hold_next_left got=%h exp=0010", gl);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort();
        logic [11:0] lsamp;
        logic [15:0] lword;
        bus.left_in  = 12'($urandom);
        bus.right_in = 12'($urandom);
        restart();
        for (int i = 0; i < 20 * 2 * DIV; i++) begin
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.left_in  = 12'($urandom);
            bus.right_in = 12'($urandom);
            cycle();
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%b exp=0000", i, obs);
            end
        end
        lsamp = 12'($urandom) | 12'h800;   // positive sample, MSB word bit is 0
        if ($urandom_range(0, 1) == 1) lsamp = lsamp & 12'h7FF;
        lword = to_word(lsamp);
        bus.left_in = lsamp;
        bus.enable  = 1'b1;
        cycle();
        checks++;
        if (bus.sample_strobe !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_strobe got=%b exp=1", bus.sample_strobe);
        end
        for (int i = 1; i <= 2 * DIV; i++) begin
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL abort_restart cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
        end
        checks++;
        if (bus.i2s_sdata !== lword[15]) begin
            errors++;
            $display("FAIL abort_left_msb got=%b exp=%b", bus.i2s_sdata, lword[15]);
        end
    endtask

`ifdef WTS_I2S_MUTE_EN
    // ------------------------------------------------------------------
    task automatic test_mute();
        logic [15:0] gl1, gl2, gr2;
        gl1 = '0; gl2 = 16'hFFFF; gr2 = 16'hFFFF;
        tb_mute      = 1'b0;
        bus.left_in  = 12'hFFF;
        bus.right_in = 12'hFFF;
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            int b;
            if (i == 100) tb_mute = 1'b1;
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL mute cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
            b = (i % FRAME) / (2 * DIV);
            if ((i % (2 * DIV)) == DIV) begin
                if (i < FRAME && b >= 1 && b <= 16) gl1[16 - b] = bus.i2s_sdata;
                if (i >= FRAME && b >= 1 && b <= 16) gl2[16 - b] = bus.i2s_sdata;
                if (i >= FRAME && b >= 33 && b <= 48) gr2[48 - b] = bus.i2s_sdata;
            end
        end
        tb_mute = 1'b0;
        checks++;
        if (gl1 !== 16'h7FF0) begin
            errors++;
            $display("FAIL mute_current_left got=%h exp=7ff0", gl1);
        end
        checks++;
        if (gl2 !== 16'h0000 || gr2 !== 16'h0000) begin
            errors++;
            $display("FAIL mute_next_frame got=%h/%h exp=0000/0000", gl2, gr2);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    task automatic test_random();
        bus.left_in  = 12'($urandom);
        bus.right_in = 12'($urandom);
        restart();
        for (int i = 0; i < 4 * FRAME; i++) begin
            bus.left_in  = 12'($urandom);
            bus.right_in = 12'($urandom);
`ifdef WTS_I2S_MUTE_EN
            tb_mute = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 399) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(0, 19) == 0) bus.enable = 1'b1;
            cycle();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, model_out());
            end
        end
        tb_mute = 1'b0;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.left_in  = 12'h800;
        bus.right_in = 12'h800;
        @(negedge clk);
        test_reset();
        test_fullscale();
        test_timing();
        test_hold();
        test_abort();
`ifdef WTS_I2S_MUTE_EN
        test_mute();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule

`default_nettype wire
